// File: rtl/dic_pkg.sv
// Shared types and constants for the digital-clock key controller.
package dic_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_STOP  = 3'd1,
    ST_LD_MT = 3'd2,
    ST_LD_MO = 3'd3,
    ST_LD_ST = 3'd4,
    ST_LD_SO = 3'd5
  } dicState_t;

  localparam logic [7:0] KEY_R   = 8'h72;
  localparam logic [7:0] KEY_S   = 8'h73;
  localparam logic [7:0] KEY_N   = 8'h6E;
  localparam logic [7:0] KEY_L   = 8'h6C;
  localparam logic [7:0] KEY_ESC = 8'h1B;
  localparam logic [7:0] KEY_0   = 8'h30;

  localparam logic [3:0] MAX_MT = 4'd5;
  localparam logic [3:0] MAX_MO = 4'd9;
  localparam logic [3:0] MAX_ST = 4'd5;
  localparam logic [3:0] MAX_SO = 4'd9;

  function automatic logic [3:0] digitLimit(input dicState_t s);
    case (s)
      ST_LD_MT: digitLimit = MAX_MT;
      ST_LD_ST: digitLimit = MAX_ST;
      ST_LD_SO: digitLimit = MAX_SO;
      default:  digitLimit = MAX_MO;
    endcase
  endfunction

  function automatic logic isLoadState(input dicState_t s);
    isLoadState = (s == ST_LD_MT) || (s == ST_LD_MO) || (s == ST_LD_ST) || (s == ST_LD_SO);
  endfunction

endpackage

// File: rtl/dic_digit_chk.sv
// Classifies an ASCII key as a decimal digit and range-checks it; purely combinational.
module dic_digit_chk
  import dic_pkg::*;
(
  input  logic [7:0] keyCode,
  input  logic [3:0] maxDigit,
  output logic       isDigit,
  output logic       inRange,
  output logic [3:0] digitVal
);

  logic [7:0] offset;

  // Codes below '0' wrap to large values, so one upper compare covers both ends.
  assign offset   = keyCode - KEY_0;
  assign isDigit  = (offset <= 8'd9);
  assign digitVal = offset[3:0];
  assign inRange  = isDigit && (digitVal <= maxDigit);

endmodule

// File: rtl/dic_ctrl.sv
// Key-strobe FSM driving run/stop, LED digit select and the MM:SS digit-load strobes.
// All outputs registered, response one cycle after key_valid; no backpressure, one key per cycle at most.
module dic_ctrl
  import dic_pkg::*;
#(
  parameter bit RUN_AFTER_LOAD = 1'b1,
  parameter bit RUN_AT_RESET   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       dicRun,
  output logic       dicSelectLEDdisp,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       load_mode,
  output logic       err
);

  localparam dicState_t RESET_STATE = RUN_AT_RESET ? ST_RUN : ST_STOP;

  dicState_t  state, stateNext, exitState;
  logic       savedRun, savedRunNext;
  logic       selNext, errNext;
  logic [3:0] ldStbNext;
  logic [3:0] ldNumNext;
  logic       isDigit, inRange;
  logic [3:0] digitVal;

  dic_digit_chk uDigitChk (
    .keyCode  (key_code),
    .maxDigit (digitLimit(state)),
    .isDigit  (isDigit),
    .inRange  (inRange),
    .digitVal (digitVal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      savedRun <= RUN_AT_RESET;
    end else begin
      state    <= stateNext;
      savedRun <= savedRunNext;
    end
  end

  always_comb begin
    stateNext    = state;
    savedRunNext = savedRun;
    selNext      = 1'b0;
    errNext      = 1'b0;
    ldStbNext    = 4'b0000;
    ldNumNext    = ld_num;
    exitState    = RUN_AFTER_LOAD ? ST_RUN : (savedRun ? ST_RUN : ST_STOP);
    if (key_valid) begin
      case (state)
        ST_RUN, ST_STOP: begin
          case (key_code)
            KEY_R: stateNext = ST_RUN;
            KEY_S: stateNext = ST_STOP;
            KEY_N: selNext   = 1'b1;
            KEY_L: begin
              savedRunNext = (state == ST_RUN);
              stateNext    = ST_LD_MT;
            end
            default: ;
          endcase
        end
        default: begin
          if (key_code == KEY_ESC) begin
            stateNext = savedRun ? ST_RUN : ST_STOP;
          end else if (!inRange) begin
            errNext = 1'b1;
          end else begin
            ldNumNext = digitVal;
            case (state)
              ST_LD_MT: begin ldStbNext = 4'b1000; stateNext = ST_LD_MO; end
              ST_LD_MO: begin ldStbNext = 4'b0100; stateNext = ST_LD_ST; end
              ST_LD_ST: begin ldStbNext = 4'b0010; stateNext = ST_LD_SO; end
              default:  begin ldStbNext = 4'b0001; stateNext = exitState; end
            endcase
          end
        end
      endcase
    end
  end

  // Outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dicRun           <= RUN_AT_RESET;
      dicSelectLEDdisp <= 1'b0;
      {ldMtens, ldMones, ldStens, ldSones} <= 4'b0000;
      ld_num           <= 4'd0;
      load_mode        <= 1'b0;
      err              <= 1'b0;
    end else begin
      dicRun           <= (stateNext == ST_RUN);
      dicSelectLEDdisp <= selNext;
      {ldMtens, ldMones, ldStens, ldSones} <= ldStbNext;
      ld_num           <= ldNumNext;
      load_mode        <= isLoadState(stateNext);
      err              <= errNext;
    end
  end

endmodule
